ring_freq_counter: RTL and testbench

RING_FREQ_COUNTER -- requirements
Module: ring_freq_counter

---
 rtl/ring_meas_pkg.sv | 15 +
 rtl/ring_sync_edge.sv | 28 ++
 rtl/ring_freq_counter.sv | 115 +++++++++++
 tb/tb_ring_freq_counter.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/ring_meas_pkg.sv
// rtl/ring_meas_pkg.sv - shared widths, settle default and FSM state type for ring measurement
package ring_meas_pkg;

    localparam int GATE_W_DEF     = 16;
    localparam int CNT_W_DEF      = 16;
    localparam int SETTLE_CYC_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_COUNT  = 2'd2,
        ST_DONE   = 2'd3
    } meas_state_t;

endpackage

// File: rtl/ring_sync_edge.sv
// rtl/ring_sync_edge.sv - 2-flop synchronizer and rising-edge detector for the ring oscillator
(* keep_hierarchy = "yes" *)
module ring_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic i_ring,
    output logic o_edge
);

    logic r_meta;
    logic r_sync;
    logic r_dly;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_dly  <= 1'b0;
        end else begin
            r_meta <= i_ring;
            r_sync <= r_meta;
            r_dly  <= r_sync;
        end
    end

    assign o_edge = r_sync & ~r_dly;

endmodule

// File: rtl/ring_freq_counter.sv
// rtl/ring_freq_counter.sv - gated edge counter measuring a tapped ring oscillator
module ring_freq_counter
    import ring_meas_pkg::*;
#(
    parameter int GATE_W     = GATE_W_DEF,
    parameter int CNT_W      = CNT_W_DEF,
    parameter int SETTLE_CYC = SETTLE_CYC_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [2:0]        tap_sel,
    input  logic [GATE_W-1:0] gate_len,
    input  logic              ring_in,
    input  logic              out_ready,
    output logic              ring_en,
    output logic [2:0]        ring_tap,
    output logic              busy,
    output logic [CNT_W-1:0]  count,
    output logic              overflow,
    output logic              out_valid
);

    localparam logic [CNT_W-1:0] CNT_MAX     = '1;
    localparam logic [7:0]       SETTLE_LOAD = 8'(SETTLE_CYC - 1);

    logic              w_edge;
    meas_state_t       r_state;
    logic [GATE_W-1:0] r_gate;
    logic [7:0]        r_settle;
    logic [CNT_W-1:0]  r_count;
    logic              r_ovf;
    logic              r_ring_en;
    logic [2:0]        r_tap;
    logic              r_busy;
    logic              r_valid;

    ring_sync_edge u_sync (
        .clk    (clk),
        .rst    (rst),
        .i_ring (ring_in),
        .o_edge (w_edge)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_gate    <= '0;
            r_settle  <= '0;
            r_count   <= '0;
            r_ovf     <= 1'b0;
            r_ring_en <= 1'b0;
            r_tap     <= 3'd0;
            r_busy    <= 1'b0;
            r_valid   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start && (gate_len != '0)) begin
                        r_state   <= ST_SETTLE;
                        r_tap     <= tap_sel;
                        r_gate    <= gate_len;
                        r_settle  <= SETTLE_LOAD;
                        r_count   <= '0;
                        r_ovf     <= 1'b0;
                        r_ring_en <= 1'b1;
                        r_busy    <= 1'b1;
                    end
                end
                ST_SETTLE: begin
                    if (r_settle == 8'd0) begin
                        r_state <= ST_COUNT;
                    end else begin
                        r_settle <= r_settle - 8'd1;
                    end
                end
                ST_COUNT: begin
                    // edges on the final window cycle still count
                    if (w_edge) begin
                        if (r_count == CNT_MAX) begin
                            r_ovf <= 1'b1;
                        end else begin
                            r_count <= r_count + CNT_W'(1);
                        end
                    end
                    if (r_gate == GATE_W'(1)) begin
                        r_state   <= ST_DONE;
                        r_ring_en <= 1'b0;
                        r_valid   <= 1'b1;
                    end else begin
                        r_gate <= r_gate - GATE_W'(1);
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_state <= ST_IDLE;
                        r_valid <= 1'b0;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign ring_en   = r_ring_en;
    assign ring_tap  = r_tap;
    assign busy      = r_busy;
    assign count     = r_count;
    assign overflow  = r_ovf;
    assign out_valid = r_valid;

endmodule

// File: tb/tb_ring_freq_counter.sv
// tb/tb_ring_freq_counter.sv - directed self-checking bench for ring_freq_counter
module tb_ring_freq_counter;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  tap_sel;
    logic [15:0] gate_len;
    logic        ring_in;
    logic        out_ready;

    logic        ring_en,  ring_en4;
    logic [2:0]  ring_tap, ring_tap4;
    logic        busy,     busy4;
    logic [15:0] count;
    logic [3:0]  count4;
    logic        overflow, overflow4;
    logic        out_valid, out_valid4;

    int n_vec  = 0;
    int n_miss = 0;
    int ring_mode = 0;
    int ring_div  = 0;
    int lat;
    int flag;
    logic [15:0] saved;

    always #5 clk = ~clk;

    ring_freq_counter u_dut (
        .clk(clk), .rst(rst), .start(start), .tap_sel(tap_sel), .gate_len(gate_len),
        .ring_in(ring_in), .out_ready(out_ready), .ring_en(ring_en), .ring_tap(ring_tap),
        .busy(busy), .count(count), .overflow(overflow), .out_valid(out_valid)
    );

    ring_freq_counter #(.CNT_W(4)) u_dut4 (
        .clk(clk), .rst(rst), .start(start), .tap_sel(tap_sel), .gate_len(gate_len),
        .ring_in(ring_in), .out_ready(out_ready), .ring_en(ring_en4), .ring_tap(ring_tap4),
        .busy(busy4), .count(count4), .overflow(overflow4), .out_valid(out_valid4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // mode 0: low, 1: period 10 clk, 2: period 2 clk, 3: stuck high
    initial begin
        ring_in = 1'b0;
        forever begin
            @(negedge clk);
            case (ring_mode)
                0: ring_in = 1'b0;
                1: begin
                    ring_div++;
                    if (ring_div >= 5) begin
                        ring_div = 0;
                        ring_in  = ~ring_in;
                    end
                end
                2: ring_in = ~ring_in;
                default: ring_in = 1'b1;
            endcase
        end
    end

    task automatic start_meas(input logic [2:0] tap, input logic [15:0] gl);
        @(negedge clk);
        tap_sel  = tap;
        gate_len = gl;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        tap_sel  = ~tap;
        gate_len = 16'hFFFF;
    endtask

    task automatic wait_valid(output int l);
        l = 1;
        while (!out_valid && l < 400) begin
            @(posedge clk);
            #1;
            l++;
        end
        if (!out_valid) chk("valid_timeout", 32'(out_valid), 32'd1);
    endtask

    task automatic handshake();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("hs_valid", 32'(out_valid), 32'd0);
        chk("hs_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; out_ready = 1'b0; tap_sel = 3'd0; gate_len = 16'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ring_en", 32'(ring_en), 32'd0);
        chk("rst_ring_tap", 32'(ring_tap), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // period-10 ring over a 100-cycle window
        ring_mode = 1;
        start_meas(3'd3, 16'd100);
        chk("s1_ring_en", 32'(ring_en), 32'd1);
        chk("s1_busy", 32'(busy), 32'd1);
        chk("s1_tap_early", 32'(ring_tap), 32'd3);
        wait_valid(lat);
        chk("s1_latency", 32'(lat), 32'd109);
        chk("s1_count", 32'(count), 32'd10);
        chk("s1_overflow", 32'(overflow), 32'd0);
        chk("s1_ring_en_done", 32'(ring_en), 32'd0);
        chk("s1_ring_tap", 32'(ring_tap), 32'd3);
        handshake();

        // fast ring saturates the 4-bit instance
        ring_mode = 2;
        start_meas(3'd5, 16'd64);
        wait_valid(lat);
        chk("s2_latency", 32'(lat), 32'd73);
        chk("s2_count16", 32'(count), 32'd32);
        chk("s2_ovf16", 32'(overflow), 32'd0);
        chk("s2_count4", 32'(count4), 32'd15);
        chk("s2_ovf4", 32'(overflow4), 32'd1);
        handshake();

        // ring stuck high through the window
        ring_mode = 3;
        repeat (5) @(posedge clk);
        start_meas(3'd1, 16'd50);
        wait_valid(lat);
        chk("s6_latency", 32'(lat), 32'd59);
        chk("s6_count", 32'(count), 32'd0);
        chk("s6_overflow", 32'(overflow), 32'd0);
        chk("s6_ovf4_cleared", 32'(overflow4), 32'd0);
        handshake();

        // DONE held 20 cycles with a stray start
        ring_mode = 1;
        start_meas(3'd7, 16'd20);
        wait_valid(lat);
        chk("s3_latency", 32'(lat), 32'd29);
        chk("s3_count", 32'(count), 32'd2);
        saved = count;
        flag = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            start    = (i == 10);
            tap_sel  = 3'd2;
            gate_len = 16'd5;
            @(posedge clk);
            #1;
            if (out_valid !== 1'b1 || count !== saved || busy !== 1'b1) flag++;
        end
        start = 1'b0;
        chk("s3_stable", 32'(flag), 32'd0);
        chk("s3_tap_held", 32'(ring_tap), 32'd7);
        @(negedge clk);
        out_ready = 1'b1;
        start     = 1'b1;
        gate_len  = 16'd10;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        start     = 1'b0;
        chk("s3_hs_valid", 32'(out_valid), 32'd0);
        chk("s3_hs_busy", 32'(busy), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("s3_idle_after", 32'(busy), 32'd0);

        // zero gate length request is dropped
        @(negedge clk);
        start    = 1'b1;
        gate_len = 16'd0;
        flag = 0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            if (busy || ring_en || out_valid) flag++;
        end
        chk("s4_ignored", 32'(flag), 32'd0);

        // reset in the middle of COUNT
        ring_mode = 1;
        start_meas(3'd4, 16'd100);
        repeat (30) @(posedge clk);
        #1;
        chk("s5_counting", 32'(count != 16'd0), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("s5_ring_en", 32'(ring_en), 32'd0);
        chk("s5_ring_tap", 32'(ring_tap), 32'd0);
        chk("s5_busy", 32'(busy), 32'd0);
        chk("s5_count", 32'(count), 32'd0);
        chk("s5_overflow", 32'(overflow), 32'd0);
        chk("s5_out_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        flag = 0;
        for (int i = 0; i < 150; i++) begin
            @(posedge clk);
            #1;
            if (out_valid || busy) flag++;
        end
        chk("s5_no_valid", 32'(flag), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
